// File: rtl/fifo_pkg.sv
// Shared types and sizing for the FIFO write path.
// The write-port arbiter and its round-robin picker use these defaults.
package fifo_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int NUM_REQ    = 4;
    localparam int MAX_BURST  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request at or after ptr, wrapping.
// Zero latency; no backpressure, found is simply the OR of all requests.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic           unused_hi;
    logic [IW-1:0]  off;
    logic [IW:0]    sum;

    // Rotating the doubled vector right by ptr puts request ptr at bit 0.
    assign dbl       = {req, req} >> ptr;
    assign rot       = dbl[N-1:0];
    assign unused_hi = ^dbl[2*N-1:N];

    always_comb begin
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IW'(i);
            end
        end
    end

    assign sum   = {1'b0, ptr} + {1'b0, off};
    assign idx   = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
    assign found = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among producers, bursts of up to MAX_BURST.
// One idle arbitration cycle per burst; full stalls the grant with ready and wr_en low.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = fifo_pkg::NUM_REQ,
    parameter int MAX_BURST  = fifo_pkg::MAX_BURST,
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          full,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_idx,
    output logic                          busy
);

    import fifo_pkg::*;

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] ptr_after_grant;
    logic [CW-1:0] burst_cnt;
    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          grant_vld;
    logic          last_beat;
    logic          burst_end;

    rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign grant_vld       = req_valid[grant_idx];
    assign wr_data         = req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign last_beat       = (burst_cnt == CW'(MAX_BURST - 1));
    // A dropped request ends the burst even while full is holding it.
    assign burst_end       = !grant_vld || (wr_en && last_beat);
    assign ptr_after_grant = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_found) state_nxt = BURST;
            BURST:   if (burst_end)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == BURST);
        wr_en     = busy && grant_vld && !full && !rst;
        req_ready = '0;
        if (busy && !full && !rst) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            grant_idx <= '0;
            burst_cnt <= '0;
        end else if (state == IDLE) begin
            if (pick_found) begin
                grant_idx <= pick_idx;
                burst_cnt <= '0;
            end
        end else begin
            if (wr_en) begin
                burst_cnt <= burst_cnt + CW'(1);
            end
            if (burst_end) begin
                rr_ptr <= ptr_after_grant;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-scenario tasks with a write scoreboard of (grant, data).
// A second 3-requester instance covers pointer wrap at a non-power-of-two size.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        full;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic [1:0]  grant_idx;
    logic        busy;

    logic [2:0]  req_valid3;
    logic [23:0] req_data3;
    logic [2:0]  req_ready3;
    logic        wr_en3;
    logic [7:0]  wr_data3;
    logic [1:0]  grant3;
    logic        busy3;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   beat[4];
    int   tests_run;
    int   tests_failed;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(4), .MAX_BURST(4), .DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .full      (full),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    fifo_wr_arbiter #(.NUM_REQ(3), .MAX_BURST(4), .DATA_WIDTH(8)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid3),
        .req_data  (req_data3),
        .req_ready (req_ready3),
        .full      (full),
        .wr_en     (wr_en3),
        .wr_data   (wr_data3),
        .grant_idx (grant3),
        .busy      (busy3)
    );

    function automatic logic [7:0] pdata(input int i, input int k);
        return 8'(i * 64 + k);
    endfunction

    task automatic drive_data();
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = pdata(i, beat[i]);
    endtask

    // Producers advance to their next data word after each accepted handshake.
    task automatic adv();
        logic [3:0] hs;
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (hs[i]) beat[i]++;
        drive_data();
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = '0;
        req_valid3 = '0;
        full       = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) beat[i] = 0;
        drive_data();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 4'b1111;
        full      = 1'b0;
        for (int i = 0; i < 4; i++) beat[i] = 0;
        drive_data();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tests_run++;
            if (wr_en !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_outputs c=%0d wr_en=%b req_ready=%b busy=%b required 0/0000/0",
                         c, wr_en, req_ready, busy);
            end
            adv();
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_arb_cycle busy=%b required 0", busy);
        end
        adv();
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b1 || grant_idx !== 2'd0 || req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL reset_first_grant busy=%b grant=%0d ready=%b required 1/0/0001",
                     busy, grant_idx, req_ready);
        end
        adv();
    endtask

    task automatic test_rotation();
        int   seq[5] = '{0, 1, 2, 3, 0};
        int   nb[4]  = '{0, 0, 0, 0};
        exp_t e;
        logic exp_wr;
        do_reset();
        for (int s = 0; s < 5; s++) begin
            for (int k = 0; k < 4; k++) begin
                exp_q.push_back({2'(seq[s]), pdata(seq[s], nb[seq[s]])});
                nb[seq[s]]++;
            end
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            exp_wr = (c % 5) != 0;
            tests_run++;
            if (wr_en !== exp_wr) begin
                tests_failed++;
                $display("FAIL rot_wr_en c=%0d wr_en=%b required %b", c, wr_en, exp_wr);
            end
            if (c % 5 == 1) begin
                tests_run++;
                if (grant_idx !== 2'(seq[c/5])) begin
                    tests_failed++;
                    $display("FAIL rot_grant c=%0d grant=%0d required %0d", c, grant_idx, seq[c/5]);
                end
            end
            if (wr_en === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests_run++;
                if (wr_data !== e.data || grant_idx !== e.idx) begin
                    tests_failed++;
                    $display("FAIL rot_write c=%0d grant=%0d data=%h required %0d/%h",
                             c, grant_idx, wr_data, e.idx, e.data);
                end
            end
            adv();
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL rot_drain left=%0d required 0", exp_q.size());
        end
        req_valid = '0;
    endtask

    task automatic test_early_release();
        exp_t e;
        logic exp_wr;
        do_reset();
        exp_q.push_back({2'd2, pdata(2, 0)});
        exp_q.push_back({2'd2, pdata(2, 1)});
        exp_q.push_back({2'd3, pdata(3, 0)});
        for (int c = 0; c < 6; c++) begin
            req_valid = (c < 3) ? 4'b0100 : (c == 3) ? 4'b0000 : 4'b1010;
            @(negedge clk);
            exp_wr = (c == 1 || c == 2 || c == 5);
            tests_run++;
            if (wr_en !== exp_wr) begin
                tests_failed++;
                $display("FAIL early_wr_en c=%0d wr_en=%b required %b", c, wr_en, exp_wr);
            end
            if (c == 4) begin
                tests_run++;
                if (busy !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL early_idle busy=%b required 0", busy);
                end
            end
            if (c == 5) begin
                tests_run++;
                if (busy !== 1'b1 || grant_idx !== 2'd3) begin
                    tests_failed++;
                    $display("FAIL early_next_grant busy=%b grant=%0d required 1/3", busy, grant_idx);
                end
            end
            if (wr_en === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests_run++;
                if (wr_data !== e.data || grant_idx !== e.idx) begin
                    tests_failed++;
                    $display("FAIL early_write c=%0d grant=%0d data=%h required %0d/%h",
                             c, grant_idx, wr_data, e.idx, e.data);
                end
            end
            adv();
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL early_drain left=%0d required 0", exp_q.size());
        end
        req_valid = '0;
    endtask

    task automatic test_full_stall();
        exp_t e;
        logic exp_wr;
        do_reset();
        for (int k = 0; k < 4; k++) exp_q.push_back({2'd1, pdata(1, k)});
        for (int c = 0; c < 14; c++) begin
            req_valid = (c <= 11) ? 4'b0010 : 4'b0000;
            full      = (c >= 3 && c <= 7) || (c >= 11 && c <= 12);
            @(negedge clk);
            exp_wr = (c == 1 || c == 2 || c == 8 || c == 9);
            tests_run++;
            if (wr_en !== exp_wr) begin
                tests_failed++;
                $display("FAIL full_wr_en c=%0d wr_en=%b required %b", c, wr_en, exp_wr);
            end
            if (c >= 3 && c <= 7) begin
                tests_run++;
                if (req_ready !== 4'b0000 || busy !== 1'b1 || grant_idx !== 2'd1) begin
                    tests_failed++;
                    $display("FAIL full_hold c=%0d ready=%b busy=%b grant=%0d required 0000/1/1",
                             c, req_ready, busy, grant_idx);
                end
            end
            if (c == 10 || c == 13) begin
                tests_run++;
                if (busy !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL full_burst_end c=%0d busy=%b required 0", c, busy);
                end
            end
            if (wr_en === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests_run++;
                if (wr_data !== e.data || grant_idx !== e.idx) begin
                    tests_failed++;
                    $display("FAIL full_write c=%0d grant=%0d data=%h required %0d/%h",
                             c, grant_idx, wr_data, e.idx, e.data);
                end
            end
            adv();
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL full_drain left=%0d required 0", exp_q.size());
        end
        req_valid = '0;
        full      = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        exp_t e;
        logic exp_wr;
        do_reset();
        for (int k = 0; k < 4; k++) exp_q.push_back({2'd0, pdata(0, k)});
        exp_q.push_back({2'd1, pdata(1, 0)});
        exp_q.push_back({2'd1, pdata(1, 1)});
        exp_q.push_back({2'd0, pdata(0, 4)});
        req_valid = 4'b1111;
        for (int c = 0; c < 11; c++) begin
            rst = (c == 8);
            @(negedge clk);
            exp_wr = (c >= 1 && c <= 4) || c == 6 || c == 7 || c == 10;
            tests_run++;
            if (wr_en !== exp_wr) begin
                tests_failed++;
                $display("FAIL rstmid_wr_en c=%0d wr_en=%b required %b", c, wr_en, exp_wr);
            end
            if (c == 8) begin
                tests_run++;
                if (req_ready !== 4'b0000) begin
                    tests_failed++;
                    $display("FAIL rstmid_ready ready=%b required 0000", req_ready);
                end
            end
            if (c == 9) begin
                tests_run++;
                if (busy !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL rstmid_idle busy=%b required 0", busy);
                end
            end
            if (c == 10) begin
                tests_run++;
                if (busy !== 1'b1 || grant_idx !== 2'd0) begin
                    tests_failed++;
                    $display("FAIL rstmid_regrant busy=%b grant=%0d required 1/0", busy, grant_idx);
                end
            end
            if (wr_en === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests_run++;
                if (wr_data !== e.data || grant_idx !== e.idx) begin
                    tests_failed++;
                    $display("FAIL rstmid_write c=%0d grant=%0d data=%h required %0d/%h",
                             c, grant_idx, wr_data, e.idx, e.data);
                end
            end
            adv();
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL rstmid_drain left=%0d required 0", exp_q.size());
        end
        rst       = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_sparse_wrap();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            req_valid = (c < 2) ? 4'b0100 : (c == 2) ? 4'b0000 : 4'b0001;
            @(negedge clk);
            if (c == 3) begin
                tests_run++;
                if (busy !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL wrap_idle busy=%b required 0", busy);
                end
            end
            if (c == 4) begin
                tests_run++;
                if (busy !== 1'b1 || grant_idx !== 2'd0 || wr_en !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL wrap_grant0 busy=%b grant=%0d wr_en=%b required 1/0/1",
                             busy, grant_idx, wr_en);
                end
            end
            adv();
        end
        req_valid = '0;
    endtask

    task automatic test_wrap3();
        logic [1:0] exp_g;
        logic       exp_wr;
        do_reset();
        req_valid3 = 3'b111;
        for (int c = 0; c < 17; c++) begin
            @(negedge clk);
            exp_wr = (c % 5) != 0;
            tests_run++;
            if (wr_en3 !== exp_wr) begin
                tests_failed++;
                $display("FAIL wrap3_wr_en c=%0d wr_en=%b required %b", c, wr_en3, exp_wr);
            end
            if (c % 5 == 1) begin
                exp_g = 2'((c / 5) % 3);
                tests_run++;
                if (busy3 !== 1'b1 || grant3 !== exp_g) begin
                    tests_failed++;
                    $display("FAIL wrap3_grant c=%0d busy=%b grant=%0d required 1/%0d",
                             c, busy3, grant3, exp_g);
                end
            end
            adv();
        end
        req_valid3 = '0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        req_valid3   = '0;
        req_data3    = 24'hC3B2A1;
        test_reset();
        test_rotation();
        test_early_release();
        test_full_stall();
        test_reset_mid_burst();
        test_sparse_wrap();
        test_wrap3();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
